uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
Serialises bytes onto the UART line. It is the transmit-side counterpart of the team's 16x-oversampled UART receiver and runs on the same oversampling clock: one bit period equals OVERSAMPLE clk cycles. A one-byte holding register lets the CPU/peripheral bus queue the next byte while the current frame shifts out, so consecutive frames go out with no idle gap. The block sits beside the receiver in the UART peripheral.

Parameters:
OVERSAMPLE, 16, clk cycles per bit period; legal range 2..32.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
clk  input  1  oversampling clock, OVERSAMPLE x baud rate.
reset  input  1  synchronous reset, active-high.
TX_DATA  input  8  byte to send; sampled only on an accepted TX_EN.
TX_EN  input  1  one-cycle write strobe.
TX_STATUS  output  1  1 = holding register empty, so TX_EN will be accepted.
TX_BUSY  output  1  1 = a frame is on the line (any state except IDLE).
TX_DONE  output  1  one-cycle pulse in the final cycle of the last stop bit.
TX_OVERRUN  output  1  one-cycle pulse when TX_EN arrives while TX_STATUS = 0.
UART_TX  output  1  serial line; idles high.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. Reset has priority over every other event.
- Reset values: UART_TX = 1, TX_STATUS = 1, TX_BUSY = 0, TX_DONE = 0, TX_OVERRUN = 0. All counters and the shifter clear, the holding register empties, and the FSM goes to IDLE.
- Reset mid-frame: the frame is aborted and UART_TX is 1 in the cycle after the reset edge. No TX_DONE is generated.
- Accept: TX_EN = 1 with TX_STATUS = 1 at an edge latches TX_DATA into the holding register. TX_STATUS drops to 0 at that edge.
- Overrun: TX_EN = 1 with TX_STATUS = 0 leaves TX_DATA ignored and the held byte unchanged, and pulses TX_OVERRUN for the next cycle.
- Registered outputs: all outputs are registered; there is no combinational path from input to output.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: UART_TX = 1. If the holding register is full, move the byte into the shifter, empty the holding register (TX_STATUS = 1) and go to START.
  - START: UART_TX = 0 for OVERSAMPLE cycles.
  - DATA: 8 bits, LSB first, each held OVERSAMPLE cycles. A 3-bit index counts 0..7.
  - PARITY: present only when PARITY_MODE != 0; one bit period. Even mode sends the XOR of the 8 data bits; odd mode sends its inverse. When PARITY_MODE = 0, DATA goes straight to STOP.
  - STOP: UART_TX = 1 for STOP_BITS x OVERSAMPLE cycles. TX_DONE pulses in the last cycle. In that same cycle, if the holding register is full, the byte is loaded and the FSM goes directly to START (zero-gap back-to-back); otherwise it goes to IDLE.
- Latency: an accepted TX_EN at edge n while IDLE gives UART_TX = 0 from edge n+2 (one cycle to hold, one cycle to load). Every bit lasts exactly OVERSAMPLE cycles.
- Frame length: (1 + 8 + P + STOP_BITS) x OVERSAMPLE cycles, where P = 1 if parity is enabled, else 0. With the defaults this is 160.
- Tick counter: width $clog2(OVERSAMPLE); counts 0..OVERSAMPLE-1, wraps to 0 at each bit boundary, and is held at 0 in IDLE.
- Simultaneous events: TX_EN accepted in the same cycle the holding register is transferred to the shifter is legal. Transfer and accept happen in one edge; TX_STATUS stays 0 and the new byte is held.
- TX_BUSY = 1 from START entry to the end of STOP. It stays 1 across back-to-back frames.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP; 3 bits);
  - parity-mode constants PAR_NONE = 0, PAR_EVEN = 1, PAR_ODD = 2;
  - UART_DATA_BITS = 8;
  - default OVERSAMPLE.
- Sub-module uart_bit_timer: oversample tick counter with a clear input and a one-cycle bit_end output. It is reusable by the receiver later.
- Holding register and FSM stay in the top module.

Test Plan:
- Default 8N1, reset then TX_EN with 0x55 -> UART_TX low 2 cycles later, then the 16-cycle-per-bit pattern 0,1,0,1,0,1,0,1,0,1. TX_DONE pulses at cycle 160 of the frame and TX_BUSY falls after it.
- Back-to-back: write 0xA5, then 0x3C as soon as TX_STATUS returns to 1 -> two contiguous 160-cycle frames with no high gap between them. Two TX_DONE pulses 160 cycles apart.
- PARITY_MODE = 1, 0x07 -> parity bit 1. PARITY_MODE = 2, 0x07 -> parity bit 0. Frame is 176 cycles.
- Overrun: write 0x11, then 0x22 (held), then 0x33 while TX_STATUS = 0 -> TX_OVERRUN pulses once; line carries 0x11 then 0x22; 0x33 never appears.
- Reset asserted at cycle 50 of a frame -> UART_TX = 1 and TX_STATUS = 1 next cycle, no TX_DONE, and a fresh write transmits correctly afterwards.
- Loopback into UART_receiver (its reset driven inverted) with random bytes 0x00..0xFF, STOP_BITS = 2 -> every byte appears on RX_DATA with an RX_STATUS pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver: FSM states,
// parity-mode encodings, frame constants and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int UART_DATA_BITS          = 8;
    localparam int UART_DEFAULT_OVERSAMPLE = 16;

    // Even mode sends the XOR of the data bits; odd mode sends its inverse.
    function automatic logic parity_bit(input logic [UART_DATA_BITS-1:0] data,
                                        input int mode);
        return (mode == PAR_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Oversample tick counter: counts 0..OVERSAMPLE-1, flags the last tick of each
// bit period, and is held at 0 while clear is high.
module uart_bit_timer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int W = $clog2(OVERSAMPLE);

    logic [W-1:0] r_count;

    assign bit_end = (r_count == W'(OVERSAMPLE - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (bit_end) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + W'(1);
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter with a one-byte holding register; frames go out LSB first
// with optional parity and 1 or 2 stop bits, back-to-back without idle gaps.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = UART_DEFAULT_OVERSAMPLE,
    parameter int PARITY_MODE = PAR_NONE,
    parameter int STOP_BITS   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [UART_DATA_BITS-1:0] TX_DATA,
    input  logic                      TX_EN,
    output logic                      TX_STATUS,
    output logic                      TX_BUSY,
    output logic                      TX_DONE,
    output logic                      TX_OVERRUN,
    output logic                      UART_TX
);

    uart_state_t               r_state;
    uart_state_t               w_state_next;
    logic [UART_DATA_BITS-1:0] r_hold;
    logic                      r_hold_full;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_parity;
    logic [2:0]                r_bit_idx;
    logic                      r_stop_idx;
    logic                      r_tx;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_overrun;

    logic w_bit_end;
    logic w_load;
    logic w_done;
    logic w_line;
    logic w_accept;

    uart_bit_timer #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_bit_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (r_state == IDLE),
        .bit_end(w_bit_end)
    );

    // A write is also taken in the very cycle the held byte moves to the shifter.
    assign w_accept = TX_EN && (!r_hold_full || w_load);

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_done       = 1'b0;
        w_line       = 1'b1;
        case (r_state)
            IDLE: begin
                if (r_hold_full) begin
                    w_load       = 1'b1;
                    w_state_next = START;
                end
            end
            START: begin
                w_line = 1'b0;
                if (w_bit_end) w_state_next = DATA;
            end
            DATA: begin
                w_line = r_shift[0];
                if (w_bit_end && r_bit_idx == 3'(UART_DATA_BITS - 1)) begin
                    w_state_next = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
                end
            end
            PARITY: begin
                w_line = r_parity;
                if (w_bit_end) w_state_next = STOP;
            end
            STOP: begin
                if (w_bit_end && r_stop_idx == 1'(STOP_BITS - 1)) begin
                    w_done = 1'b1;
                    if (r_hold_full) begin
                        w_load       = 1'b1;
                        w_state_next = START;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs are registered from the current state, so the line trails the FSM by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_bit_idx   <= '0;
            r_stop_idx  <= 1'b0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_tx      <= w_line;
            r_busy    <= (r_state != IDLE);
            r_done    <= w_done;
            r_overrun <= TX_EN && !w_accept;

            if (w_accept) begin
                r_hold      <= TX_DATA;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end

            if (w_load) begin
                r_shift    <= r_hold;
                r_parity   <= parity_bit(r_hold, PARITY_MODE);
                r_bit_idx  <= '0;
                r_stop_idx <= 1'b0;
            end else begin
                if (r_state == DATA && w_bit_end) begin
                    r_shift   <= r_shift >> 1;
                    r_bit_idx <= r_bit_idx + 3'd1;
                end
                if (r_state == STOP && w_bit_end) begin
                    r_stop_idx <= r_stop_idx + 1'b1;
                end
            end
        end
    end

    assign TX_STATUS  = ~r_hold_full;
    assign TX_BUSY    = r_busy;
    assign TX_DONE    = r_done;
    assign TX_OVERRUN = r_overrun;
    assign UART_TX    = r_tx;

endmodule

// File: tb/tb_uart_transmitter.sv
// Three transmitters (8N1/16x, even-parity/16x, odd-parity 2-stop/8x) driven by
// shared stimulus and checked every cycle against a frame-countdown model.
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_en;
    logic [7:0] tx_data;
    logic [2:0] w_tx, w_st, w_busy, w_done, w_ovr;

    always #5 clk = ~clk;

    uart_transmitter #(.OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .reset(reset), .TX_DATA(tx_data), .TX_EN(tx_en),
        .TX_STATUS(w_st[0]), .TX_BUSY(w_busy[0]), .TX_DONE(w_done[0]),
        .TX_OVERRUN(w_ovr[0]), .UART_TX(w_tx[0]));
    uart_transmitter #(.OVERSAMPLE(16), .PARITY_MODE(1), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .reset(reset), .TX_DATA(tx_data), .TX_EN(tx_en),
        .TX_STATUS(w_st[1]), .TX_BUSY(w_busy[1]), .TX_DONE(w_done[1]),
        .TX_OVERRUN(w_ovr[1]), .UART_TX(w_tx[1]));
    uart_transmitter #(.OVERSAMPLE(8), .PARITY_MODE(2), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .reset(reset), .TX_DATA(tx_data), .TX_EN(tx_en),
        .TX_STATUS(w_st[2]), .TX_BUSY(w_busy[2]), .TX_DONE(w_done[2]),
        .TX_OVERRUN(w_ovr[2]), .UART_TX(w_tx[2]));

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic chk_en = 1'b0;

    function automatic int os_of(input int i);
        return (i == 2) ? 8 : 16;
    endfunction
    function automatic int pm_of(input int i);
        return i;
    endfunction
    function automatic int sb_of(input int i);
        return (i == 2) ? 2 : 1;
    endfunction
    function automatic int flen(input int i);
        return (9 + ((pm_of(i) != 0) ? 1 : 0) + sb_of(i)) * os_of(i);
    endfunction
    // Line value of bit k of a frame: start, 8 data LSB first, optional parity, stops.
    function automatic logic fbit(input int i, input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == 9 && pm_of(i) != 0) return (pm_of(i) == 2) ? ~(^b) : (^b);
        return 1'b1;
    endfunction

    // Model: m_left counts the remaining cycles of the frame being serialised.
    int         m_left [3];
    logic       m_hv   [3];
    logic [7:0] m_hb   [3];
    logic [7:0] m_fb   [3];
    logic [2:0] e_tx, e_st, e_busy, e_done, e_ovr;
    logic [7:0] sent_q[$];
    logic [7:0] rx_q[$];
    int         done_cyc[$];
    int         ovr_cnt0 = 0;
    logic [7:0] dec_b;

    function automatic logic m_xfer(input int i);
        return m_hv[i] && (m_left[i] <= 1);
    endfunction
    function automatic logic m_acc(input int i);
        return tx_en && (!m_hv[i] || m_left[i] <= 1);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                m_left[i] <= 0;
                m_hv[i]   <= 1'b0;
                e_tx[i]   <= 1'b1;
                e_st[i]   <= 1'b1;
                e_busy[i] <= 1'b0;
                e_done[i] <= 1'b0;
                e_ovr[i]  <= 1'b0;
            end else begin
                e_done[i] <= (m_left[i] == 1);
                e_busy[i] <= (m_left[i] > 0);
                e_tx[i]   <= (m_left[i] > 0) ?
                             fbit(i, m_fb[i], (flen(i) - m_left[i]) / os_of(i)) : 1'b1;
                m_left[i] <= m_xfer(i) ? flen(i) : ((m_left[i] > 0) ? m_left[i] - 1 : 0);
                if (m_xfer(i)) begin
                    m_fb[i] <= m_hb[i];
                    if (i == 0) sent_q.push_back(m_hb[i]);
                end
                if (m_acc(i)) m_hb[i] <= tx_data;
                m_hv[i]  <= m_acc(i) || (m_hv[i] && !m_xfer(i));
                e_st[i]  <= !(m_acc(i) || (m_hv[i] && !m_xfer(i)));
                e_ovr[i] <= tx_en && !m_acc(i);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle compare of every output of every instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("uart_tx%0d", i), int'(w_tx[i]),   int'(e_tx[i]));
                chk($sformatf("status%0d", i),  int'(w_st[i]),   int'(e_st[i]));
                chk($sformatf("busy%0d", i),    int'(w_busy[i]), int'(e_busy[i]));
                chk($sformatf("done%0d", i),    int'(w_done[i]), int'(e_done[i]));
                chk($sformatf("overrun%0d", i), int'(w_ovr[i]),  int'(e_ovr[i]));
            end
            if (w_done[0] === 1'b1) done_cyc.push_back(cyc);
            if (w_ovr[0] === 1'b1) ovr_cnt0++;
        end
    end

    // Independent line decoder for the 8N1 instance (mid-bit sampling).
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && w_tx[0] === 1'b0) begin
                repeat (8) @(negedge clk);
                for (int j = 0; j < 8; j++) begin
                    repeat (16) @(negedge clk);
                    dec_b[j] = w_tx[0];
                end
                repeat (16) @(negedge clk);
                if (w_tx[0] === 1'b1) rx_q.push_back(dec_b);
            end
        end
    end

    task automatic send(input logic [7:0] b);
        tx_data = b;
        tx_en   = 1'b1;
        @(negedge clk);
        tx_en   = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (n < 2000 && !(m_left[0] == 0 && m_left[1] == 0 && m_left[2] == 0 &&
                             !m_hv[0] && !m_hv[1] && !m_hv[2] && w_busy == 3'b000)) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", int'(n < 2000), 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic skip_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        int t0;
        int nw;
        reset   = 1'b1;
        tx_en   = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_tx", int'(w_tx[0]), 1);
        chk("reset_status", int'(w_st[0]), 1);
        chk("reset_busy", int'(w_busy[0]), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 0x55 on 8N1: start low two edges after the accept, 16 cycles per bit.
        send(8'h55);
        t0 = cyc;
        skip_to(t0 + 1);  chk("lat_n1_high", int'(w_tx[0]), 1);
        skip_to(t0 + 2);  chk("lat_n2_start", int'(w_tx[0]), 0);
        skip_to(t0 + 18); chk("bit0_0x55", int'(w_tx[0]), 1);
        skip_to(t0 + 34); chk("bit1_0x55", int'(w_tx[0]), 0);
        skip_to(t0 + 161);
        chk("done_at_160", int'(w_done[0]), 1);
        chk("busy_at_160", int'(w_busy[0]), 1);
        skip_to(t0 + 162);
        chk("busy_falls", int'(w_busy[0]), 0);
        wait_idle();

        // 0x07: even parity bit 1, odd parity bit 0; 176-cycle parity frame.
        send(8'h07);
        t0 = cyc;
        skip_to(t0 + 78);  chk("odd_parity_0x07", int'(w_tx[2]), 0);
        skip_to(t0 + 154); chk("even_parity_0x07", int'(w_tx[1]), 1);
        skip_to(t0 + 177); chk("done_at_176", int'(w_done[1]), 1);
        skip_to(t0 + 178); chk("busy_after_176", int'(w_busy[1]), 0);
        wait_idle();

        // Back-to-back frames.
        rx_q.delete();
        done_cyc.delete();
        send(8'hA5);
        nw = 0;
        while (w_st[0] !== 1'b1 && nw < 400) begin
            @(negedge clk);
            nw++;
        end
        chk("status_return", int'(nw < 400), 1);
        send(8'h3C);
        wait_idle();
        chk("b2b_done_count", done_cyc.size(), 2);
        if (done_cyc.size() == 2) chk("b2b_done_spacing", done_cyc[1] - done_cyc[0], 160);
        chk("b2b_rx_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            chk("b2b_rx0", int'(rx_q[0]), 'hA5);
            chk("b2b_rx1", int'(rx_q[1]), 'h3C);
        end

        // Overrun: 0x11 then 0x22 in the transfer cycle, then 0x33 while full.
        rx_q.delete();
        ovr_cnt0 = 0;
        tx_en   = 1'b1;
        tx_data = 8'h11;
        @(negedge clk);
        tx_data = 8'h22;
        @(negedge clk);
        tx_data = 8'h33;
        @(negedge clk);
        tx_en = 1'b0;
        wait_idle();
        chk("overrun_pulses", ovr_cnt0, 1);
        chk("ovr_rx_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            chk("ovr_rx0", int'(rx_q[0]), 'h11);
            chk("ovr_rx1", int'(rx_q[1]), 'h22);
        end

        // Reset at cycle 50 of a frame aborts it cleanly.
        send(8'h5A);
        repeat (49) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_tx", int'(w_tx[0]), 1);
        chk("abort_status", int'(w_st[0]), 1);
        chk("abort_done", int'(w_done[0]), 0);
        repeat (200) @(negedge clk);
        rx_q.delete();
        send(8'hC3);
        wait_idle();
        chk("post_reset_rx_count", rx_q.size(), 1);
        if (rx_q.size() == 1) chk("post_reset_rx", int'(rx_q[0]), 'hC3);

        // Random traffic, including overruns and back-to-back loads.
        rx_q.delete();
        sent_q.delete();
        for (int k = 0; k < 6000; k++) begin
            tx_en   = ($urandom_range(0, 39) == 0);
            tx_data = 8'($urandom);
            @(negedge clk);
        end
        tx_en = 1'b0;
        wait_idle();
        chk("rand_rx_count", rx_q.size(), sent_q.size());
        for (int k = 0; k < rx_q.size() && k < sent_q.size(); k++) begin
            chk($sformatf("rand_rx%0d", k), int'(rx_q[k]), int'(sent_q[k]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
